// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared opcode encodings, FSM state type and opcode decode
//               helper for the accumulator-CPU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    // Opcodes 0..OP_ALU_MAX are forwarded to the ALU unchanged
    localparam logic [5:0] OP_ALU_MAX = 6'd17;
    localparam logic [5:0] OP_LOAD    = 6'd18;
    localparam logic [5:0] OP_STORE   = 6'd19;
    localparam logic [5:0] OP_PUSH    = 6'd20;
    localparam logic [5:0] OP_POP     = 6'd21;
    localparam logic [5:0] OP_INP     = 6'd26;
    localparam logic [5:0] OP_OUT     = 6'd27;
    localparam logic [5:0] OP_BRZ     = 6'd32;
    localparam logic [5:0] OP_BRN     = 6'd33;
    localparam logic [5:0] OP_BRC     = 6'd34;
    localparam logic [5:0] OP_BRO     = 6'd35;
    localparam logic [5:0] OP_BRA     = 6'd36;
    localparam logic [5:0] OP_JMP     = 6'd37;
    localparam logic [5:0] OP_RET     = 6'd38;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ALU_WAIT  = 2'd1,
        ST_PUSH_WAIT = 2'd2,
        ST_POP_WAIT  = 2'd3
    } cu_state_e;

    // True for every opcode that has a defined meaning
    function automatic logic op_is_defined(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        if (op <= OP_POP)                      ok = 1'b1;
        else if (op == OP_INP || op == OP_OUT) ok = 1'b1;
        else if (op >= OP_BRZ && op <= OP_RET) ok = 1'b1;
        return ok;
    endfunction

endpackage : cu_pkg
`default_nettype wire

// File: rtl/cu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cu_seq_if
// Description : Instruction, ALU, stack and redirect signals of the control
//               unit. The slave modport is the control unit's view; master is
//               the surrounding fetch/datapath view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cu_seq_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instruction;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc;
    logic          fl_zero;
    logic          fl_negative;
    logic          fl_carry;
    logic          fl_overflow;
    logic          alu_enable;
    logic [5:0]    alu_opcode;
    logic [DW-1:0] term1;
    logic [DW-1:0] term2;
    logic          alu_done;
    logic [DW-1:0] alu_out;
    logic          push_req;
    logic [DW-1:0] push_data;
    logic          push_done;
    logic          pop_req;
    logic          pop_done;
    logic [DW-1:0] pop_out;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          branch;
    logic [AW-1:0] pc_out;
    logic          done;
    logic          illegal_op;

    modport slave (
        input  instr_valid, instruction, imm, pc,
               fl_zero, fl_negative, fl_carry, fl_overflow,
               alu_done, alu_out, push_done, pop_done, pop_out,
        output instr_ready, alu_enable, alu_opcode, term1, term2,
               push_req, push_data, pop_req, out_valid, out_data,
               branch, pc_out, done, illegal_op
    );

    modport master (
        output instr_valid, instruction, imm, pc,
               fl_zero, fl_negative, fl_carry, fl_overflow,
               alu_done, alu_out, push_done, pop_done, pop_out,
        input  instr_ready, alu_enable, alu_opcode, term1, term2,
               push_req, push_data, pop_req, out_valid, out_data,
               branch, pc_out, done, illegal_op
    );

endinterface : cu_seq_if
`default_nettype wire

// File: rtl/cu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cu_regfile
// Description : NREG x DW index register file, one synchronous write port,
//               one combinational read port, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_regfile #(
    parameter  int DW   = 16,
    parameter  int NREG = 2,
    localparam int RW   = $clog2(NREG)
) (
    input  wire logic          clk,
    input  wire logic          rst_b,
    input  wire logic          we_i,
    input  wire logic [RW-1:0] waddr_i,
    input  wire logic [DW-1:0] wdata_i,
    input  wire logic [RW-1:0] raddr_i,
    output logic      [DW-1:0] rdata_o
);

    logic [DW-1:0] regs_q [NREG];

    // Register storage: cleared on reset, single write per cycle
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // NREG is a power of two, so every index value addresses a real register
    assign rdata_o = regs_q[raddr_i];

endmodule : cu_regfile
`default_nettype wire

// File: rtl/cu_seq.sv
`default_nettype none
// ============================================================================
// Module      : cu_seq
// Description : Sequential control unit for the accumulator CPU. Accepts one
//               instruction at a time, owns acc / lr / index registers and
//               sequences multi-cycle ALU and stack operations.
//               Optional feature macro: CU_TRAP_EN (undefined opcodes pulse
//               illegal_op together with done).
// Revision    : 1.0 - initial release
// ============================================================================
module cu_seq
    import cu_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int AW   = 10,
    parameter  int NREG = 2,
    localparam int RW   = $clog2(NREG)
) (
    input wire logic clk,
    input wire logic rst_b,
    cu_seq_if.slave  bus
);

    cu_state_e     state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] lr_q, lr_d;
    logic [5:0]    opcode_q, opcode_d;
    logic [DW-1:0] term1_q, term1_d;
    logic [DW-1:0] term2_q, term2_d;
    logic [DW-1:0] push_data_q, push_data_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] pc_out_q, pc_out_d;
    logic          done_q, done_d;
    logic          branch_q, branch_d;
    logic          out_valid_q, out_valid_d;

    logic          w_accept;
    logic [5:0]    w_op;
    logic [RW-1:0] w_idx;
    logic          w_rf_we;
    logic [DW-1:0] w_rf_rdata;
    logic          w_unused_instr;

    assign w_op     = bus.instruction[15:10];
    assign w_idx    = bus.instruction[9 -: RW];
    assign w_accept = bus.instr_valid && (state_q == ST_IDLE);

    // Instruction bits below the register index carry no meaning here
    assign w_unused_instr = ^bus.instruction[9-RW:0];

    cu_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_b   (rst_b),
        .we_i    (w_rf_we),
        .waddr_i (w_idx),
        .wdata_i (acc_q),
        .raddr_i (w_idx),
        .rdata_o (w_rf_rdata)
    );

`ifdef CU_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and retire pulses
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        lr_d        = lr_q;
        opcode_d    = opcode_q;
        term1_d     = term1_q;
        term2_d     = term2_q;
        push_data_d = push_data_q;
        out_data_d  = out_data_q;
        pc_out_d    = pc_out_q;
        done_d      = 1'b0;
        branch_d    = 1'b0;
        out_valid_d = 1'b0;
        w_rf_we     = 1'b0;
`ifdef CU_TRAP_EN
        illegal_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    opcode_d = w_op;
                    if (w_op <= OP_ALU_MAX) begin
                        term1_d = acc_q;
                        term2_d = w_rf_rdata;
                        state_d = ST_ALU_WAIT;
                    end else begin
                        // Single-cycle ops retire next cycle unless overridden
                        done_d = 1'b1;
                        case (w_op)
                            OP_LOAD:  acc_d   = w_rf_rdata;
                            OP_STORE: w_rf_we = 1'b1;
                            OP_PUSH: begin
                                push_data_d = acc_q;
                                state_d     = ST_PUSH_WAIT;
                                done_d      = 1'b0;
                            end
                            OP_POP: begin
                                state_d = ST_POP_WAIT;
                                done_d  = 1'b0;
                            end
                            OP_INP:   acc_d = bus.imm;
                            OP_OUT: begin
                                out_data_d  = acc_q;
                                out_valid_d = 1'b1;
                            end
                            OP_BRZ: begin
                                branch_d = bus.fl_zero;
                                pc_out_d = bus.imm[AW-1:0];
                            end
                            OP_BRN: begin
                                branch_d = bus.fl_negative;
                                pc_out_d = bus.imm[AW-1:0];
                            end
                            OP_BRC: begin
                                branch_d = bus.fl_carry;
                                pc_out_d = bus.imm[AW-1:0];
                            end
                            OP_BRO: begin
                                branch_d = bus.fl_overflow;
                                pc_out_d = bus.imm[AW-1:0];
                            end
                            OP_BRA: begin
                                branch_d = 1'b1;
                                pc_out_d = bus.imm[AW-1:0];
                            end
                            OP_JMP: begin
                                branch_d = 1'b1;
                                pc_out_d = bus.imm[AW-1:0];
                                lr_d     = bus.pc;
                            end
                            OP_RET: begin
                                branch_d = 1'b1;
                                pc_out_d = lr_q;
                            end
                            default: begin
`ifdef CU_TRAP_EN
                                illegal_d = !op_is_defined(w_op);
`else
                                // Undefined opcodes retire as NOP
                                done_d = 1'b1;
`endif
                            end
                        endcase
                    end
                end
            end
            ST_ALU_WAIT: begin
                if (bus.alu_done) begin
                    acc_d   = bus.alu_out;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH_WAIT: begin
                if (bus.push_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_POP_WAIT: begin
                if (bus.pop_done) begin
                    acc_d   = bus.pop_out;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural registers, latched operands and registered pulses
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q       <= '0;
            lr_q        <= '0;
            opcode_q    <= '0;
            term1_q     <= '0;
            term2_q     <= '0;
            push_data_q <= '0;
            out_data_q  <= '0;
            pc_out_q    <= '0;
            done_q      <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            lr_q        <= lr_d;
            opcode_q    <= opcode_d;
            term1_q     <= term1_d;
            term2_q     <= term2_d;
            push_data_q <= push_data_d;
            out_data_q  <= out_data_d;
            pc_out_q    <= pc_out_d;
            done_q      <= done_d;
            branch_q    <= branch_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CU_TRAP_EN
    // Trap pulse register, only present when trapping is built in
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    // Requests are levels derived from the wait state, so reset drops them
    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.alu_enable  = (state_q == ST_ALU_WAIT);
    assign bus.push_req    = (state_q == ST_PUSH_WAIT);
    assign bus.pop_req     = (state_q == ST_POP_WAIT);
    assign bus.alu_opcode  = opcode_q;
    assign bus.term1       = term1_q;
    assign bus.term2       = term2_q;
    assign bus.push_data   = push_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.branch      = branch_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.done        = done_q;

endmodule : cu_seq
`default_nettype wire
